// File: rtl/cpu8_mem_pkg.sv
// Shared definitions for the 8-bit CPU memory blocks: bus widths,
// RW window placement, clear-sequencer states and an index-width helper.
package cpu8_mem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;

    localparam int unsigned RW_BASE  = 128;
    localparam int unsigned RW_DEPTH = 96;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Bits needed to index depth words; never below 1 so DEPTH=1 still gets a port.
    function automatic int unsigned idx_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < depth) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rw_window_ram_sync_if.sv
// CPU data-bus view of one windowed RAM instance.
interface rw_window_ram_sync_if
    import cpu8_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              hit;
    logic              miss;
    logic              busy;

    modport master (
        output write, read, address, data_in,
        input  data_out, rd_valid, hit, miss, busy
    );

    modport slave (
        input  write, read, address, data_in,
        output data_out, rd_valid, hit, miss, busy
    );
endinterface

// File: rtl/rw_window_ram_sync_ram_sp_core.sv
// Single-port DEPTH x DATA_W storage: one write port, registered read,
// write-first when read and write coincide. No reset on the array.
module ram_sp_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 96,
    parameter int unsigned IDX_W  = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array write and read-register update; read data holds while re_i is low.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/rw_window_ram_sync.sv
// Address-windowed synchronous RAM on the CPU data bus. Answers only
// [BASE, BASE+DEPTH); optionally zeroes itself after reset before serving.
module rw_window_ram_sync
    import cpu8_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned BASE           = RW_BASE,
    parameter int unsigned DEPTH          = RW_DEPTH,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    rw_window_ram_sync_if.slave  bus
);
    localparam int unsigned      IDX_W       = idx_w(DEPTH);
    localparam logic [ADDR_W:0]  WIN_LO      = (ADDR_W + 1)'(BASE);
    localparam logic [ADDR_W:0]  WIN_HI      = (ADDR_W + 1)'(BASE + DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam state_e           RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clear_ptr_q, clear_ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic               miss_q, miss_d;
    logic               rd_seen_q, rd_seen_d;

    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic               core_we, core_re;
    logic [IDX_W-1:0]   core_addr;
    logic [DATA_W-1:0]  core_wdata, core_rdata;

    // Window decode one bit wider than the bus so BASE+DEPTH = 2**ADDR_W fits.
    always_comb begin
        hit = ({1'b0, bus.address} >= WIN_LO) && ({1'b0, bus.address} < WIN_HI);
        idx = IDX_W'(bus.address - ADDR_W'(BASE));
    end

    // Next-state, array control and flag updates for the clear/serve FSM.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        rd_valid_d  = 1'b0;
        miss_d      = 1'b0;
        rd_seen_d   = rd_seen_q;
        core_we     = 1'b0;
        core_re     = 1'b0;
        core_addr   = idx;
        core_wdata  = bus.data_in;
        unique case (state_q)
            CLEAR: begin
                core_we     = 1'b1;
                core_addr   = clear_ptr_q;
                core_wdata  = '0;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LAST_IDX) state_d = READY;
            end
            READY: begin
                if (bus.read || bus.write) begin
                    if (hit) begin
                        core_we    = bus.write;
                        core_re    = bus.read;
                        rd_valid_d = bus.read;
                        if (bus.read) rd_seen_d = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and flag registers; asynchronous reset restarts any clear from index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            clear_ptr_q <= '0;
            rd_valid_q  <= 1'b0;
            miss_q      <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rd_valid_q  <= rd_valid_d;
            miss_q      <= miss_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    ram_sp_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk     (clk),
        .we_i    (core_we),
        .re_i    (core_re),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .rdata_o (core_rdata)
    );

    // The array read register has no reset, so data_out reads as zero until
    // the first accepted read after reset; afterwards the register holds the value.
    assign bus.data_out = rd_seen_q ? core_rdata : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.miss     = miss_q;
    assign bus.hit      = hit;
    assign bus.busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_rw_window_ram_sync.sv
// Directed bench for rw_window_ram_sync: default 96x8 window plus a
// 16-bit instance placed at the top of the address space.
module tb_rw_window_ram_sync;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rw_window_ram_sync_if #(.DATA_W(8),  .ADDR_W(8))  bus8();
    rw_window_ram_sync_if #(.DATA_W(16), .ADDR_W(16)) bus16();

    rw_window_ram_sync #(
        .DATA_W(8), .ADDR_W(8), .BASE(128), .DEPTH(96), .CLEAR_ON_RESET(1'b1)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    rw_window_ram_sync #(
        .DATA_W(16), .ADDR_W(16), .BASE(32'hFFC0), .DEPTH(64), .CLEAR_ON_RESET(1'b1)
    ) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] din;
        logic       exp_hit;
        logic       exp_valid;
        logic       exp_miss;
        logic [7:0] exp_dout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive8(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
        bus8.write   = wr;
        bus8.read    = rd;
        bus8.address = a;
        bus8.data_in = d;
    endtask

    vec_t vecs[18];
    int   ncyc;

    initial begin
        drive8(1'b0, 1'b0, 8'h00, 8'h00);
        bus16.write   = 1'b0;
        bus16.read    = 1'b0;
        bus16.address = 16'h0000;
        bus16.data_in = 16'h0000;

        //                wr    rd    addr  din   hit   vld   miss  dout
        vecs[0]  = '{1'b0, 1'b1, 8'd128, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'd175, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'd223, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'd100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'd130, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'd130, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 1'b0, 8'd130, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b1, 1'b0, 8'd127, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[8]  = '{1'b1, 1'b0, 8'd224, 8'h22, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[9]  = '{1'b0, 1'b0, 8'd224, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[10] = '{1'b1, 1'b0, 8'd223, 8'h33, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[11] = '{1'b0, 1'b1, 8'd223, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[12] = '{1'b0, 1'b1, 8'd128, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 1'b1, 8'd200, 8'h5C, 1'b1, 1'b1, 1'b0, 8'h5C};
        vecs[14] = '{1'b0, 1'b1, 8'd200, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5C};
        vecs[15] = '{1'b0, 1'b1, 8'd140, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 8'd127, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 8'd129, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        // Reset state.
        #12;
        chk("rst_busy",     16'(bus8.busy),     16'h1);
        chk("rst_rd_valid", 16'(bus8.rd_valid), 16'h0);
        chk("rst_miss",     16'(bus8.miss),     16'h0);
        chk("rst_data_out", 16'(bus8.data_out), 16'h00);

        // First clear, with a write to 140 held on the bus; reset after 40 cycles.
        @(negedge clk);
        reset = 1'b0;
        drive8(1'b1, 1'b1, 8'd140, 8'hFF);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("clr_busy_c40",     16'(bus8.busy),     16'h1);
        chk("clr_rd_valid_c40", 16'(bus8.rd_valid), 16'h0);
        chk("clr_miss_c40",     16'(bus8.miss),     16'h0);
        reset = 1'b1;
        #1;
        chk("midclr_rst_busy", 16'(bus8.busy), 16'h1);

        // Restarted clear must last a full 96 cycles; requests are still ignored.
        @(negedge clk);
        reset = 1'b0;
        ncyc = 0;
        while (bus8.busy && ncyc < 200) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (ncyc == 50) begin
                chk("clr_rd_valid_c50", 16'(bus8.rd_valid), 16'h0);
                chk("clr_miss_c50",     16'(bus8.miss),     16'h0);
            end
        end
        chk("clear_cycles", 16'(ncyc), 16'd96);
        chk("dut16_ready",  16'(bus16.busy), 16'h0);

        // Table-driven vectors, one request cycle each.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive8(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
            #1;
            chk($sformatf("v%0d_hit", i), 16'(bus8.hit), 16'(vecs[i].exp_hit));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rd_valid", i), 16'(bus8.rd_valid), 16'(vecs[i].exp_valid));
            chk($sformatf("v%0d_miss", i),     16'(bus8.miss),     16'(vecs[i].exp_miss));
            chk($sformatf("v%0d_data_out", i), 16'(bus8.data_out), 16'(vecs[i].exp_dout));
        end
        @(negedge clk);
        drive8(1'b0, 1'b0, 8'h00, 8'h00);

        // Wide instance at the top of a 16-bit space.
        bus16.address = 16'hFFBF;
        bus16.write   = 1'b1;
        bus16.data_in = 16'h1234;
        #1;
        chk("w16_hit_ffbf", 16'(bus16.hit), 16'h0);
        @(posedge clk);
        #1;
        chk("w16_miss_ffbf", 16'(bus16.miss), 16'h1);
        @(negedge clk);
        bus16.address = 16'h0000;
        bus16.write   = 1'b0;
        #1;
        chk("w16_hit_0000", 16'(bus16.hit), 16'h0);
        bus16.address = 16'hFFC0;
        #1;
        chk("w16_hit_ffc0", 16'(bus16.hit), 16'h1);
        bus16.address = 16'hFFFF;
        bus16.write   = 1'b1;
        bus16.data_in = 16'hBEEF;
        #1;
        chk("w16_hit_ffff", 16'(bus16.hit), 16'h1);
        @(posedge clk);
        #1;
        chk("w16_miss_ffff", 16'(bus16.miss), 16'h0);
        @(negedge clk);
        bus16.write = 1'b0;
        bus16.read  = 1'b1;
        @(posedge clk);
        #1;
        chk("w16_rd_valid", 16'(bus16.rd_valid), 16'h1);
        chk("w16_data_out", bus16.data_out,      16'hBEEF);
        @(negedge clk);
        bus16.read    = 1'b1;
        bus16.address = 16'hFFC0;
        @(posedge clk);
        #1;
        chk("w16_data_ffc0", bus16.data_out, 16'h0000);
        @(negedge clk);
        bus16.read = 1'b0;

        // Reset in the cycle after a read: rd_valid and data_out drop at once.
        drive8(1'b0, 1'b1, 8'd130, 8'h00);
        @(posedge clk);
        #1;
        chk("pre_rst_rd_valid", 16'(bus8.rd_valid), 16'h1);
        chk("pre_rst_data_out", 16'(bus8.data_out), 16'hA5);
        drive8(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        chk("midrd_rst_rd_valid", 16'(bus8.rd_valid), 16'h0);
        chk("midrd_rst_data_out", 16'(bus8.data_out), 16'h00);
        chk("midrd_rst_busy",     16'(bus8.busy),     16'h1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
